// File: rtl/uart_packet_sequencer.sv
// UART packet sequencer: parses framed host packets and
// echoes payloads or returns a 32-bit add/sub result.
module uart_packet_sequencer #(
  parameter int TIMEOUT_CYCLES_P = 3225600,
  parameter int TIMEOUT_WIDTH_P  = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_tdata,
  input  logic       rx_tvalid,
  output logic       rx_tready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    HDR0, HDR1, HDR2, HDR3,
    ECHO, OPND, RES, DRAIN
  } state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_SUB  = 8'hA1;
  localparam logic [TIMEOUT_WIDTH_P-1:0] TMO_LAST =
    TIMEOUT_WIDTH_P'(TIMEOUT_CYCLES_P - 1);

  state_t state, state_n;
  logic        err_n;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] plen;
  logic [15:0] cnt;
  logic [1:0]  bidx;
  logic        first;
  logic [31:0] opnd;
  logic [31:0] opnd_n;
  logic [31:0] acc;
  logic [31:0] acc_n;
  logic [2:0]  res_cnt;
  logic [TIMEOUT_WIDTH_P-1:0] tmo;
  logic        timed;
  logic        tmo_hit;
  logic        rx_xfer;
  logic        tx_xfer;
  logic        tx_free;
  logic        last;
  logic        is_echo;
  logic        is_alu;
  logic        tx_load;
  logic [7:0]  tx_byte;

  assign rx_xfer = rx_tvalid && rx_tready;
  assign tx_xfer = tx_tvalid && tx_tready;
  assign tx_free = !tx_tvalid || tx_tready;
  assign len     = {rx_tdata, len_lo};
  assign plen    = len - 16'd4;
  assign last    = (cnt == 16'd1);
  assign is_echo = (opcode == OP_ECHO);
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign opnd_n  = {rx_tdata, opnd[31:8]};
  assign acc_n   = first ? opnd_n :
                   (opcode == OP_SUB) ? acc - opnd_n :
                   acc + opnd_n;
  assign timed   = (state != HDR0) && (state != RES);
  assign tmo_hit = timed && !rx_xfer && (tmo == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR0;
    else        state <= state_n;
  end

  // Next-state and error decision
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      HDR0: if (rx_xfer) state_n = HDR1;
      HDR1, HDR2: begin
        if (tmo_hit) begin
          state_n = HDR0;
          err_n   = 1'b1;
        end else if (rx_xfer) begin
          state_n = (state == HDR1) ? HDR2 : HDR3;
        end
      end
      HDR3: begin
        if (tmo_hit) begin
          state_n = HDR0;
          err_n   = 1'b1;
        end else if (rx_xfer) begin
          if (len < 16'd4) begin
            state_n = HDR0;
            err_n   = 1'b1;
          end else if (is_echo && plen == 16'd0) begin
            state_n = HDR0;
          end else if (is_echo) begin
            state_n = ECHO;
          end else if (is_alu && plen != 16'd0
                       && plen[1:0] == 2'd0) begin
            state_n = OPND;
          end else if (plen == 16'd0) begin
            state_n = HDR0;
            err_n   = 1'b1;
          end else begin
            state_n = DRAIN;
            err_n   = 1'b1;
          end
        end
      end
      ECHO, OPND, DRAIN: begin
        if (tmo_hit) begin
          state_n = HDR0;
          err_n   = 1'b1;
        end else if (rx_xfer && last) begin
          state_n = (state == OPND) ? RES : HDR0;
        end
      end
      RES: if (res_cnt == 3'd4 && tx_xfer) state_n = HDR0;
      default: state_n = HDR0;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    rx_tready = 1'b1;
    busy      = (state != HDR0);
    case (state)
      ECHO:    rx_tready = tx_free;
      RES:     rx_tready = 1'b0;
      default: rx_tready = 1'b1;
    endcase
  end

  // Select the byte to place on tx
  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (state == ECHO && rx_xfer) begin
      tx_load = 1'b1;
      tx_byte = rx_tdata;
    end else if (state == OPND && rx_xfer
                 && last && tx_free) begin
      tx_load = 1'b1;
      tx_byte = acc_n[7:0];
    end else if (state == RES && tx_free
                 && res_cnt != 3'd4) begin
      tx_load = 1'b1;
      tx_byte = acc[8*res_cnt[1:0] +: 8];
    end
  end

  // Registered tx stream, held until the transfer completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tdata  <= 8'h00;
      tx_tvalid <= 1'b0;
    end else if (tx_load) begin
      tx_tdata  <= tx_byte;
      tx_tvalid <= 1'b1;
    end else if (tx_xfer) begin
      tx_tvalid <= 1'b0;
    end
  end

  // Inter-byte timeout counter and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      err <= err_n;
      if (!timed || rx_xfer || tmo_hit) tmo <= '0;
      else                             tmo <= tmo + 1'b1;
    end
  end

  // Header capture, payload counter and operand datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode  <= 8'h00;
      len_lo  <= 8'h00;
      cnt     <= 16'h0000;
      bidx    <= 2'd0;
      first   <= 1'b0;
      opnd    <= 32'h0;
      acc     <= 32'h0;
      res_cnt <= 3'd0;
    end else begin
      if (state == HDR0 && rx_xfer) opcode <= rx_tdata;
      if (state == HDR2 && rx_xfer) len_lo <= rx_tdata;
      if (state == HDR3 && rx_xfer) begin
        cnt   <= plen;
        bidx  <= 2'd0;
        first <= 1'b1;
      end
      if ((state == ECHO || state == OPND
           || state == DRAIN) && rx_xfer)
        cnt <= cnt - 16'd1;
      if (state == OPND && rx_xfer) begin
        opnd <= opnd_n;
        bidx <= bidx + 2'd1;
        if (bidx == 2'd3) begin
          acc   <= acc_n;
          first <= 1'b0;
        end
      end
      if (state == OPND && rx_xfer && last)
        res_cnt <= tx_free ? 3'd1 : 3'd0;
      else if (state == RES && tx_load)
        res_cnt <= res_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_packet_sequencer.sv
// Directed bench for uart_packet_sequencer with a short
// timeout so stall behaviour is reachable.
module tb_uart_packet_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;
  logic       busy;
  logic       err;

  int checks;
  int errors;
  int err_cnt;
  logic [7:0] q[$];

  uart_packet_sequencer #(
    .TIMEOUT_CYCLES_P(100),
    .TIMEOUT_WIDTH_P (22)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_tdata (rx_tdata),
    .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready),
    .tx_tdata (tx_tdata),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture transmitted bytes and error pulses
  always @(posedge clk) begin
    if (tx_tvalid && tx_tready) q.push_back(tx_tdata);
    if (err) err_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    while (!rx_tready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rx_accept", {31'd0, rx_tready}, 32'd1);
    if (rx_tready) begin
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op,
                          input logic [15:0] l);
    send_byte(op);
    send_byte(8'h00);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_q(input int n);
    int c;
    c = 0;
    while (q.size() < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic chk_tx(input string tag, input int n,
                        input logic [31:0] w);
    wait_q(n);
    chk({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"},
          (i < q.size()) ? {24'd0, q[i]} : 32'hFFFF_FFFF,
          {24'd0, w[8*i +: 8]});
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] eb[3];
    int base;
    int n;
    logic stable;
    checks    = 0;
    errors    = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    rx_tdata  = 8'h00;
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    idle(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txv", {31'd0, tx_tvalid}, 32'd0);
    chk("rst_txd", {24'd0, tx_tdata}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdy", {31'd0, rx_tready}, 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Echo with one-cycle latency per byte
    eb[0] = 8'h41; eb[1] = 8'h42; eb[2] = 8'h43;
    send_hdr(8'hEC, 16'd7);
    for (int i = 0; i < 3; i++) begin
      send_byte(eb[i]);
      chk("echo_v", {31'd0, tx_tvalid}, 32'd1);
      chk("echo_d", {24'd0, tx_tdata}, {24'd0, eb[i]});
    end
    idle(2);
    chk("echo_busy", {31'd0, busy}, 32'd0);
    chk_tx("echo", 3, 32'h0043_4241);

    // Add with wrap to zero, then a plain sum
    send_hdr(8'hA0, 16'd12);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    chk("add0_v", {31'd0, tx_tvalid}, 32'd1);
    chk("add0_d", {24'd0, tx_tdata}, 32'd0);
    chk_tx("add0", 4, 32'h0000_0000);
    send_hdr(8'hA0, 16'd12);
    send_word(32'h0000_0010);
    send_word(32'h0000_0005);
    chk_tx("add1", 4, 32'h0000_0015);
    idle(2);
    chk("add_busy", {31'd0, busy}, 32'd0);

    // Subtract while the transmitter stalls
    tx_tready = 1'b0;
    send_hdr(8'hA1, 16'd12);
    send_word(32'h0000_000A);
    send_word(32'h0000_0003);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(tx_tvalid === 1'b1 && tx_tdata === 8'h07))
        stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("sub_hold", {31'd0, stable}, 32'd1);
    chk("sub_nosend", q.size(), 0);
    tx_tready = 1'b1;
    chk_tx("sub", 4, 32'h0000_0007);

    // Unknown opcode drains its payload
    base = err_cnt;
    send_hdr(8'h55, 16'd6);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(3);
    chk("unk_err", err_cnt - base, 1);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    chk("unk_notx", q.size(), 0);

    // ALU packet with misaligned payload
    send_hdr(8'hA0, 16'd6);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(3);
    chk("mis_err", err_cnt - base, 2);
    chk("mis_notx", q.size(), 0);

    // Resync after errors
    send_hdr(8'hEC, 16'd5);
    send_byte(8'h99);
    chk_tx("resync", 1, 32'h0000_0099);

    // Short length is an error without drain
    send_hdr(8'hEC, 16'd3);
    idle(3);
    chk("short_err", err_cnt - base, 3);
    chk("short_busy", {31'd0, busy}, 32'd0);

    // Inter-byte timeout inside an echo payload
    send_hdr(8'hEC, 16'd8);
    send_byte(8'h01);
    n = 0;
    while (!err && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycle", n, 100);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    idle(1);
    chk("tmo_pulse", {31'd0, err}, 32'd0);
    chk_tx("tmo_tx", 1, 32'h0000_0001);
    send_hdr(8'hEC, 16'd5);
    send_byte(8'h7E);
    chk_tx("tmo_next", 1, 32'h0000_007E);

    // Asynchronous reset in the middle of an operand
    send_hdr(8'hA0, 16'd12);
    send_byte(8'h55);
    send_byte(8'h66);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_txv", {31'd0, tx_tvalid}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_hdr(8'hA0, 16'd12);
    send_word(32'h0000_0003);
    send_word(32'h0000_0004);
    chk_tx("post_rst", 4, 32'h0000_0007);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
